sram_req_ctrl: RTL and testbench
================================

SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning SRAM row width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 100, meaning SRAM rows.
REQ-003 The block SHALL have parameter ADDR_W, default $clog2(DEPTH), meaning row address width.
REQ-004 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; one clock, reset is synchronous and active-low
- rst_n  in  1  synchronous active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_wr  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start row
- cmd_len  in  ADDR_W+1  row count
- wr_valid / wr_ready  in / out  1  write-data stream handshake
- wr_data  in  DATA_W  write row
- rd_valid / rd_ready  out / in  1  read-data stream handshake
- rd_data  out  DATA_W  read row
- mem_en, rd_req, wr_req  out  1  SRAM wrapper controls
- address  out  ADDR_W  SRAM row address
- wr_data_out  out  DATA_W  SRAM write data
- rd_data_val  in  1  SRAM read-data valid, one cycle after rd_req
- rd_data_in  in  DATA_W  SRAM read data
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst end
- err  out  1  one-cycle pulse on rejected command

Function
REQ-005 FSM states SHALL be IDLE, READ, WRITE, DRAIN; cmd_ready=1 only in IDLE.
REQ-006 On a cmd handshake with cmd_len in 1..DEPTH and cmd_addr<DEPTH, the FSM SHALL move to WRITE (cmd_wr=1) or READ (cmd_wr=0) next cycle, latching addr and len.
REQ-007 On a cmd handshake with cmd_len=0, cmd_len>DEPTH or cmd_addr>=DEPTH, the block SHALL consume the command, pulse err next cycle, issue no SRAM access, and stay IDLE.
REQ-008 rd_req and wr_req SHALL never be 1 in the same cycle; mem_en SHALL equal rd_req|wr_req.
REQ-009 WRITE: wr_ready SHALL be 1 in WRITE; each wr_valid&wr_ready cycle SHALL assert wr_req combinationally with address=current row, wr_data_out=wr_data.
REQ-010 READ: rd_req SHALL assert only when FIFO occupancy plus in-flight reads < 2; no read is lost under any rd_ready pattern.
REQ-011 rd_data_val SHALL push rd_data_in into a 2-entry FIFO; rd_valid = FIFO non-empty, rd_data = FIFO head; push and pop in the same cycle on a full FIFO SHALL be legal.
REQ-012 The row address SHALL increment per access and wrap from DEPTH-1 to 0.
REQ-013 After the last rd_req the FSM SHALL enter DRAIN until the final row is popped, then pulse done and return IDLE; after the last wr_req it SHALL pulse done next cycle and return IDLE.
REQ-014 busy SHALL be 1 in READ, WRITE, DRAIN.
REQ-015 Full-rate throughput SHALL be one row per cycle when rd_ready or wr_valid is held 1.

Reset
REQ-016 rst_n=0 at a clk edge SHALL force IDLE, empty FIFO, zero in-flight count, and all outputs 0 except cmd_ready=1, including mid-burst; a rd_data_val arriving the cycle after reset SHALL be dropped.

Configuration
REQ-017 With SRAM_REQ_CTRL_STATS_EN defined, outputs stat_rd_rows and stat_wr_rows (16 bit, saturating at 16'hFFFF, cleared by reset) SHALL count completed row reads/writes; without it, these ports and counters SHALL not exist and behaviour SHALL be otherwise identical.

Structure
REQ-018 Package ec_sram_pkg SHALL hold the FSM state enum and default DATA_W/DEPTH constants.
REQ-019 The 2-entry read FIFO SHALL be sub-module ec_skid_fifo.

Verification
REQ-020 Read addr=5 len=4, rd_ready=1 -> rd_req at rows 5,6,7,8 on consecutive cycles, 4 rd_valid beats in order, one done pulse.
REQ-021 Write addr=98 len=4, DEPTH=100 -> wr_req at rows 98,99,0,1, wr_data_out matches inputs.
REQ-022 Read len=8 with rd_ready toggling 1,0,0,1 repeating -> all 8 rows delivered in order, none lost or duplicated, never more than 2 outstanding.
REQ-023 cmd_len=0, then cmd_addr=100 -> err pulse each, no rd_req/wr_req, cmd_ready returns 1.
REQ-024 rst_n=0 mid-read (row 3 of 6) -> next cycle IDLE, rd_valid=0, busy=0, subsequent read burst correct.
REQ-025 With SRAM_REQ_CTRL_STATS_EN, write 3 rows then read 2 rows -> stat_wr_rows=3, stat_rd_rows=2.

Source files
------------

// File: rtl/ec_sram_pkg.sv
// ec_sram_pkg: FSM state encoding and default SRAM geometry shared by
// sram_req_ctrl and its testbench.
package ec_sram_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/ec_skid_fifo.sv
// ec_skid_fifo: 2-entry read-data FIFO. A push on a full FIFO is taken when a
// pop happens in the same cycle; o_head reads zero while empty.
module ec_skid_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_head,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;
  logic              w_do_pop;
  logic              w_do_push;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible while r_count != 0.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: burst command front-end for a single-port SRAM wrapper.
// Optional row statistics are built when SRAM_REQ_CTRL_STATS_EN is defined.
module sram_req_ctrl
  import ec_sram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              rd_req,
  output logic              wr_req,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wr_data_out,
  input  logic              rd_data_val,
  input  logic [DATA_W-1:0] rd_data_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
`ifdef SRAM_REQ_CTRL_STATS_EN
  ,
  output logic [15:0]       stat_rd_rows,
  output logic [15:0]       stat_wr_rows
`endif
);

  // Handshakes (cmd, wr, rd): a beat transfers in a cycle where valid and ready
  // are both 1; valid never waits on ready, and data is sampled only on a beat.

  localparam logic [ADDR_W:0]   LP_DEPTH    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_LAST_ROW = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LP_ROW_ONE  = ADDR_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remain;
  logic              r_inflight;
  logic              r_done;
  logic              r_err;

  logic              w_cmd_fire;
  logic              w_cmd_ok;
  logic              w_rd_req;
  logic              w_wr_req;
  logic              w_last_access;
  logic              w_pop;
  logic              w_push;
  logic              w_fifo_valid;
  logic [DATA_W-1:0] w_fifo_head;
  logic [1:0]        w_fifo_count;
  logic [2:0]        w_occ;

  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_cmd_ok   = (cmd_len != '0) && (cmd_len <= LP_DEPTH) &&
                      ({1'b0, cmd_addr} < LP_DEPTH);

  // A row popped this cycle frees its slot in time for a read issued now,
  // which is what keeps a held rd_ready at one row per cycle.
  assign w_pop  = w_fifo_valid && rd_ready;
  assign w_push = rd_data_val && r_inflight;
  assign w_occ  = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign w_rd_req      = (r_state == READ) && (r_remain != '0) && (w_occ < 3'd2);
  assign w_wr_req      = (r_state == WRITE) && (r_remain != '0) && wr_valid;
  assign w_last_access = (w_rd_req || w_wr_req) && (r_remain == LP_LEN_ONE);

  ec_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_rd_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (rd_data_in),
    .i_pop       (w_pop),
    .o_valid     (w_fifo_valid),
    .o_head      (w_fifo_head),
    .o_count     (w_fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_cmd_fire && w_cmd_ok) begin
          w_state_nxt = cmd_wr ? WRITE : READ;
        end
      end
      READ: begin
        if (w_last_access) begin
          w_state_nxt = DRAIN;
        end
      end
      WRITE: begin
        if (w_last_access) begin
          w_state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (!r_inflight && (w_fifo_count == 2'd1) && w_pop) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_remain   <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd_req;
      r_done     <= (r_state != IDLE) && (w_state_nxt == IDLE);
      r_err      <= w_cmd_fire && !w_cmd_ok;
      if (w_cmd_fire && w_cmd_ok) begin
        r_addr   <= cmd_addr;
        r_remain <= cmd_len;
      end else if (w_rd_req || w_wr_req) begin
        r_addr   <= (r_addr == LP_LAST_ROW) ? '0 : r_addr + LP_ROW_ONE;
        r_remain <= r_remain - LP_LEN_ONE;
      end
    end
  end

  assign cmd_ready   = (r_state == IDLE);
  assign wr_ready    = (r_state == WRITE);
  assign busy        = (r_state != IDLE);
  assign rd_req      = w_rd_req;
  assign wr_req      = w_wr_req;
  assign mem_en      = w_rd_req || w_wr_req;
  assign address     = r_addr;
  assign wr_data_out = w_wr_req ? wr_data : '0;
  assign rd_valid    = w_fifo_valid;
  assign rd_data     = w_fifo_head;
  assign done        = r_done;
  assign err         = r_err;
  assign dbg_state   = r_state;

`ifdef SRAM_REQ_CTRL_STATS_EN
  logic [15:0] r_stat_rd;
  logic [15:0] r_stat_wr;

  // A read row counts once delivered downstream; a write row once issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_rd <= 16'd0;
      r_stat_wr <= 16'd0;
    end else begin
      if (w_pop && (r_stat_rd != 16'hFFFF)) begin
        r_stat_rd <= r_stat_rd + 16'd1;
      end
      if (w_wr_req && (r_stat_wr != 16'hFFFF)) begin
        r_stat_wr <= r_stat_wr + 16'd1;
      end
    end
  end

  assign stat_rd_rows = r_stat_rd;
  assign stat_wr_rows = r_stat_wr;
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: directed bench for sram_req_ctrl with a behavioural SRAM
// (read data one cycle after rd_req) and a reference copy of memory contents.
module tb_sram_req_ctrl;
  import ec_sram_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 100;
  localparam int AW    = 7;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_wr    = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [AW:0]   cmd_len   = '0;
  logic          wr_valid  = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data   = '0;
  logic          rd_valid;
  logic          rd_ready  = 1'b0;
  logic [DW-1:0] rd_data;
  logic          mem_en;
  logic          rd_req;
  logic          wr_req;
  logic [AW-1:0] address;
  logic [DW-1:0] wr_data_out;
  logic          rd_data_val = 1'b0;
  logic [DW-1:0] rd_data_in  = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    dbg_state;
`ifdef SRAM_REQ_CTRL_STATS_EN
  logic [15:0]   stat_rd_rows;
  logic [15:0]   stat_wr_rows;
`endif

  sram_req_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .mem_en      (mem_en),
    .rd_req      (rd_req),
    .wr_req      (wr_req),
    .address     (address),
    .wr_data_out (wr_data_out),
    .rd_data_val (rd_data_val),
    .rd_data_in  (rd_data_in),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .dbg_state   (dbg_state)
`ifdef SRAM_REQ_CTRL_STATS_EN
    ,
    .stat_rd_rows(stat_rd_rows),
    .stat_wr_rows(stat_wr_rows)
`endif
  );

  function automatic logic [DW-1:0] dflt(input int row);
    return 32'hA500_0000 + DW'(row);
  endfunction

  // ---------------- SRAM model ----------------
  logic [DW-1:0] sram_mem [0:127];
  logic [127:0]  sram_wr = '0;

  always @(posedge clk) begin
    rd_data_val <= rd_req;
    rd_data_in  <= rd_req ? (sram_wr[address] ? sram_mem[address] : dflt(int'(address))) : '0;
    if (wr_req) begin
      sram_mem[address] <= wr_data_out;
      sram_wr[address]  <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] ref_mem [0:127];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [AW:0] n, input string tag);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_len   = n;
    @(negedge clk);
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
  endtask

  task automatic post_burst(input string tag, input int n_done);
    check({tag, ".done_pulses"}, 32'(n_done), 32'd1);
    @(negedge clk);
    check({tag, ".done_drop"}, 32'(done), 32'd0);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check({tag, ".idle_cmd_ready"}, 32'(cmd_ready), 32'd1);
    step();
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input logic [AW:0] n, input logic [3:0] pat,
                            input string tag);
    logic [DW-1:0] exp_q[$];
    int            exp_a[$];
    int            got_a[$];
    logic [DW-1:0] got_d[$];
    int n_req = 0, n_pop = 0, n_done = 0, max_out = 0, first_c = -1, last_c = -1, excl = 0;
    for (int i = 0; i < int'(n); i++) begin
      exp_a.push_back((int'(a) + i) % DEPTH);
      exp_q.push_back(ref_mem[(int'(a) + i) % DEPTH]);
    end
    send_cmd(1'b0, a, n, tag);
    for (int c = 0; c < 200 && n_done == 0; c++) begin
      rd_ready = pat[c % 4];
      @(negedge clk);
      if (rd_req) begin
        got_a.push_back(int'(address));
        if (first_c < 0) first_c = c;
        last_c = c;
        n_req++;
      end
      if (wr_req || (mem_en !== (rd_req | wr_req))) excl++;
      if (rd_valid && rd_ready) begin
        got_d.push_back(rd_data);
        n_pop++;
      end
      if (n_req - n_pop > max_out) max_out = n_req - n_pop;
      if (done) n_done++;
      step();
    end
    rd_ready = 1'b0;
    post_burst(tag, n_done);
    check({tag, ".n_req"}, 32'(n_req), 32'(n));
    check({tag, ".n_beats"}, 32'(n_pop), 32'(n));
    check({tag, ".mem_en_rule"}, 32'(excl), 32'd0);
    check({tag, ".outstanding_le2"}, 32'(max_out <= 2), 32'd1);
    if (pat == 4'b1111) check({tag, ".back_to_back"}, 32'(last_c - first_c), 32'(int'(n) - 1));
    for (int i = 0; i < int'(n); i++) begin
      check($sformatf("%s.row%0d", tag, i), (i < got_a.size()) ? 32'(got_a[i]) : 32'hFFFF_FFFF,
            32'(exp_a[i]));
      check($sformatf("%s.data%0d", tag, i), (i < got_d.size()) ? got_d[i] : 32'hDEAD_DEAD,
            exp_q[i]);
    end
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input logic [AW:0] n, input logic [3:0] pat,
                             input logic [DW-1:0] base, input string tag);
    int            got_a[$];
    logic [DW-1:0] got_d[$];
    int j = 0, n_req = 0, n_done = 0, first_c = -1, last_c = -1, excl = 0, rdy_bad = 0;
    send_cmd(1'b1, a, n, tag);
    for (int c = 0; c < 200 && n_done == 0; c++) begin
      wr_valid = (j < int'(n)) && pat[c % 4];
      wr_data  = (j < int'(n)) ? base + DW'(j) : '0;
      @(negedge clk);
      if (wr_req) begin
        got_a.push_back(int'(address));
        got_d.push_back(wr_data_out);
        if (first_c < 0) first_c = c;
        last_c = c;
        n_req++;
      end
      if (rd_req || (mem_en !== (rd_req | wr_req))) excl++;
      if (busy && !wr_ready) rdy_bad++;
      if (wr_valid && wr_ready) j++;
      if (done) n_done++;
      step();
    end
    wr_valid = 1'b0;
    wr_data  = '0;
    post_burst(tag, n_done);
    check({tag, ".n_req"}, 32'(n_req), 32'(n));
    check({tag, ".mem_en_rule"}, 32'(excl), 32'd0);
    check({tag, ".wr_ready_in_write"}, 32'(rdy_bad), 32'd0);
    if (pat == 4'b1111) check({tag, ".back_to_back"}, 32'(last_c - first_c), 32'(int'(n) - 1));
    for (int i = 0; i < int'(n); i++) begin
      check($sformatf("%s.row%0d", tag, i), (i < got_a.size()) ? 32'(got_a[i]) : 32'hFFFF_FFFF,
            32'((int'(a) + i) % DEPTH));
      check($sformatf("%s.data%0d", tag, i), (i < got_d.size()) ? got_d[i] : 32'hDEAD_DEAD,
            base + DW'(i));
      ref_mem[(int'(a) + i) % DEPTH] = base + DW'(i);
    end
  endtask

  task automatic bad_cmd(input logic [AW-1:0] a, input logic [AW:0] n, input string tag);
    send_cmd(1'b0, a, n, tag);
    @(negedge clk);
    check({tag, ".err_pulse"}, 32'(err), 32'd1);
    check({tag, ".no_access"}, 32'(mem_en | rd_req | wr_req), 32'd0);
    check({tag, ".stay_idle"}, 32'(dbg_state), 32'(IDLE));
    check({tag, ".cmd_ready_back"}, 32'(cmd_ready), 32'd1);
    step();
    @(negedge clk);
    check({tag, ".err_drop"}, 32'(err), 32'd0);
    check({tag, ".no_access2"}, 32'(mem_en), 32'd0);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, ".state"}, 32'(dbg_state), 32'(IDLE));
    check({tag, ".busy_done_err"}, 32'({busy, done, err}), 32'd0);
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, ".wr_ready"}, 32'(wr_ready), 32'd0);
    check({tag, ".sram_ctl"}, 32'({mem_en, rd_req, wr_req}), 32'd0);
    check({tag, ".rd_data"}, rd_data, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n_mid;
    for (int i = 0; i < 128; i++) ref_mem[i] = dflt(i);

    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset.address", 32'(address), 32'd0);
    check("reset.wr_data_out", wr_data_out, 32'd0);
    rst_n = 1'b1;
    step();

    read_burst(7'd5, 8'd4, 4'b1111, "rd_5x4");
    write_burst(7'd98, 8'd4, 4'b1111, 32'hC0DE_0000, "wr_98x4_wrap");
    read_burst(7'd97, 8'd5, 4'b1111, "rd_97x5_wrap");
    write_burst(7'd50, 8'd3, 4'b0101, 32'h5A5A_0100, "wr_50x3_gappy");
    read_burst(7'd40, 8'd8, 4'b1001, "rd_40x8_toggle");
    read_burst(7'd50, 8'd3, 4'b0110, "rd_50x3_back");
    read_burst(7'd99, 8'd1, 4'b1111, "rd_99x1_edge");

    bad_cmd(7'd5, 8'd0, "err_len0");
    bad_cmd(7'd100, 8'd1, "err_addr100");
    bad_cmd(7'd0, 8'd101, "err_len101");

    // Reset lands right after the third of six row reads is issued.
    send_cmd(1'b0, 7'd10, 8'd6, "rst_mid");
    rd_ready = 1'b1;
    n_mid = 0;
    for (int c = 0; c < 50 && n_mid < 3; c++) begin
      @(negedge clk);
      if (rd_req) n_mid++;
      if (n_mid < 3) step();
    end
    check("rst_mid.reached_row3", 32'(n_mid), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid.late_val_dropped", 32'(rd_valid), 32'd0);
    check("rst_mid.still_idle", 32'(busy), 32'd0);
    rd_ready = 1'b0;
    step();
    read_burst(7'd20, 8'd3, 4'b1111, "rd_after_rst");

`ifdef SRAM_REQ_CTRL_STATS_EN
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("stats.clear_rd", 32'(stat_rd_rows), 32'd0);
    check("stats.clear_wr", 32'(stat_wr_rows), 32'd0);
    rst_n = 1'b1;
    step();
    write_burst(7'd30, 8'd3, 4'b1111, 32'h0BAD_F000, "stats_wr");
    read_burst(7'd30, 8'd2, 4'b1111, "stats_rd");
    @(negedge clk);
    check("stats.wr_rows", 32'(stat_wr_rows), 32'd3);
    check("stats.rd_rows", 32'(stat_rd_rows), 32'd2);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
